hiscore_ram_arbiter: RTL and testbench
======================================

// Module: hiscore_ram_arbiter
// PURPOSE
//  Shares the game work-RAM port between the Z80/6809 CPU and the hiscore save/restore engine.
//  On a hiscore access request it pauses the CPU at a bus-cycle boundary and drains in-flight cycles.
//  It then hands the RAM port to hiscore and releases the CPU when hiscore drops its request.
//  Sits between the core top level (CPU RAM bus, pause input) and the hiscore ram_* ports.
// PARAMETERS
//  AW              12  RAM address width
//  DW              8   RAM data width
//  DRAIN_CYCLES    8   clk_49m cycles held in DRAIN after pause is asserted (>=1)
//  RELEASE_CYCLES  4   clk_49m cycles the port stays with CPU side before pause_n rises (>=1)
// PORTS
//  clk_49m      in   1   system clock, 49.152 MHz
//  reset        in   1   asynchronous, active-low reset
//  cpu_cen      in   1   CPU bus-cycle enable strobe (one clk wide per CPU cycle)
//  cpu_addr     in   AW  CPU RAM address
//  cpu_din      in   DW  CPU write data
//  cpu_we       in   1   CPU write enable (qualified by cpu_cen)
//  cpu_dout     out  DW  RAM read data to CPU
//  hs_access    in   1   hiscore requests RAM ownership (level)
//  hs_address   in   AW  hiscore RAM address
//  hs_data_in   in   DW  hiscore write data
//  hs_write     in   1   hiscore write strobe (1 clk)
//  hs_data_out  out  DW  RAM read data to hiscore
//  hs_grant     out  1   RAM port owned by hiscore
//  cpu_pause_n  out  1   active-low CPU pause to core; ANDed externally with user pause
//  ram_addr     out  AW  shared RAM address
//  ram_din      out  DW  shared RAM write data
//  ram_we       out  1   shared RAM write enable
//  ram_dout     in   DW  shared RAM read data (registered RAM, 1-cycle latency)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, cpu_pause_n=1, hs_grant=0, ram_we=0, counters=0,
//   cpu_dout/hs_data_out=0; mux selects CPU side.
//  States: IDLE -> PAUSE -> DRAIN -> GRANT -> RELEASE -> IDLE.
//  IDLE: mux=CPU, ram_we=cpu_we&cpu_cen. hs_access=1 -> PAUSE.
//  PAUSE: wait for the next cpu_cen pulse; in that cycle the CPU access completes normally,
//   cpu_pause_n<=0 registered on the same edge, go to DRAIN. hs_access drops first -> IDLE, no pause.
//  DRAIN: cpu_pause_n=0, mux=CPU, ram_we=0 (late CPU writes discarded); count DRAIN_CYCLES -> GRANT.
//  GRANT: hs_grant=1, mux=hiscore, ram_we=hs_write, ram_addr=hs_address. hs_data_out=ram_dout
//   (valid 1 clk after address). hs_access=0 -> RELEASE; hs_grant falls the same edge.
//  RELEASE: mux=CPU, ram_we=0, cpu_pause_n=0; count RELEASE_CYCLES, then cpu_pause_n<=1, IDLE.
//   hs_access re-asserted during RELEASE is ignored until IDLE (no back-to-back grant).
//  cpu_dout = ram_dout in every state except GRANT, where it holds the last CPU-side value.
//  Latency: hs_access rise to hs_grant = wait-for-cpu_cen + 1 + DRAIN_CYCLES clocks.
//  hs_write outside GRANT: ignored, never reaches ram_we.
//  Mux switches only on state changes; ram_we never asserted on the switch edge.
//  Counters: $clog2(max(DRAIN,RELEASE))+1 bits, load N-1, decrement to 0; no wrap.
//  Reset mid-operation: immediate return to IDLE, pause released, grant dropped, no RAM write.
// TESTING
//  1 Reset low while in GRANT -> next clk: hs_grant=0, cpu_pause_n=1, ram_we=0, mux=CPU.
//  2 hs_access=1 in IDLE, cpu_cen every 8 clks -> cpu_pause_n=0 on next cpu_cen edge;
//    hs_grant=1 exactly 1+8 clks later (DRAIN_CYCLES=8).
//  3 GRANT: hs_write addr 0x5A0 data 0x3C, then read 0x5A0 -> hs_data_out=0x3C 1 clk after address;
//    CPU read of 0x5A0 after release returns 0x3C.
//  4 CPU writes 0x77 via cpu_we during DRAIN -> RAM unchanged; hs_write=1 in IDLE -> ram_we stays 0.
//  5 hs_access pulses high then low before any cpu_cen -> returns IDLE, cpu_pause_n never 0.
//  6 hs_access drops -> hs_grant=0 same edge, cpu_pause_n=1 after 4 clks; hs_access re-raised in
//    RELEASE -> new PAUSE only after IDLE.

Source files
------------

// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter
//   Shares the game work-RAM port between the CPU and the hiscore
//   save/restore engine. A hiscore request pauses the CPU at a bus-cycle
//   boundary, lets in-flight cycles drain, and then hands the RAM port to
//   hiscore. When hiscore drops its request, the port returns to the CPU side
//   for a short settle period before the CPU is released.
//
//   Request/grant handshake: hs_access is a level request that hiscore holds
//   for the whole transaction. hs_grant is high exactly while hiscore owns the
//   port, and it falls on the same edge that sees hs_access low. hs_write and
//   hs_address are honoured only while hs_grant is high. hs_data_out is valid
//   one clock after hs_address is presented.
//
// Ports
//   clk_49m      system clock
//   reset        asynchronous active-low reset
//   cpu_cen      CPU bus-cycle enable strobe (one clock per CPU cycle)
//   cpu_addr     CPU RAM address
//   cpu_din      CPU write data
//   cpu_we       CPU write enable, qualified by cpu_cen
//   cpu_dout     RAM read data to the CPU (held while hiscore owns the port)
//   hs_access    hiscore ownership request (level)
//   hs_address   hiscore RAM address
//   hs_data_in   hiscore write data
//   hs_write     hiscore write strobe
//   hs_data_out  RAM read data to hiscore
//   hs_grant     RAM port owned by hiscore
//   cpu_pause_n  active-low CPU pause
//   ram_addr     shared RAM address
//   ram_din      shared RAM write data
//   ram_we       shared RAM write enable
//   ram_dout     shared RAM read data (registered RAM, 1-cycle latency)
//   state_dbg    current FSM state encoding, for observation only
module hiscore_ram_arbiter #(
  parameter int AW             = 12,
  parameter int DW             = 8,
  parameter int DRAIN_CYCLES   = 8,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic          clk_49m,
  input  logic          reset,
  input  logic          cpu_cen,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_dout,
  input  logic          hs_access,
  input  logic [AW-1:0] hs_address,
  input  logic [DW-1:0] hs_data_in,
  input  logic          hs_write,
  output logic [DW-1:0] hs_data_out,
  output logic          hs_grant,
  output logic          cpu_pause_n,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAUSE   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_GRANT   = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam int CMAX = (DRAIN_CYCLES > RELEASE_CYCLES) ? DRAIN_CYCLES : RELEASE_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] DRAIN_LOAD   = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LOAD = CW'(RELEASE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pause_n_q;
  logic            grant_q;
  logic [DW-1:0]   cpu_hold_q;
  logic [DW-1:0]   hs_hold_q;
  logic            sel_hs;

  // Next-state logic. Counters load N-1 on entry and the state is left on
  // the cycle the counter reads zero, so each timed state lasts N clocks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_access) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        // A request withdrawn before the CPU reached a cycle boundary
        // aborts without ever pausing the CPU.
        if (!hs_access) begin
          state_d = ST_IDLE;
        end else if (cpu_cen) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_GRANT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_GRANT: begin
        if (!hs_access) begin
          state_d = ST_RELEASE;
          cnt_d   = RELEASE_LOAD;
        end
      end
      ST_RELEASE: begin
        // hs_access is deliberately not sampled here; a new request is only
        // seen once back in IDLE.
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pause_n_q  <= 1'b1;
      grant_q    <= 1'b0;
      cpu_hold_q <= '0;
      hs_hold_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pause_n_q <= !(state_d == ST_DRAIN || state_d == ST_GRANT || state_d == ST_RELEASE);
      grant_q   <= (state_d == ST_GRANT);
      // Each side keeps the last read data it saw, so the CPU's view is
      // frozen while hiscore drives the port, and vice versa.
      if (!sel_hs) cpu_hold_q <= ram_dout;
      if (sel_hs)  hs_hold_q  <= ram_dout;
    end
  end

  // The mux select comes from the registered state only, so it changes
  // exclusively on state transitions.
  assign sel_hs = (state_q == ST_GRANT);

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = 1'b0;
    case (state_q)
      ST_IDLE:  ram_we = cpu_we & cpu_cen;
      // The boundary CPU cycle that triggers the pause completes normally.
      ST_PAUSE: ram_we = cpu_we & cpu_cen;
      ST_GRANT: begin
        ram_addr = hs_address;
        ram_din  = hs_data_in;
        ram_we   = hs_write;
      end
      default:  ram_we = 1'b0;
    endcase
  end

  assign cpu_dout    = sel_hs ? cpu_hold_q : ram_dout;
  assign hs_data_out = sel_hs ? ram_dout : hs_hold_q;
  assign hs_grant    = grant_q;
  assign cpu_pause_n = pause_n_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
module tb_hiscore_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_PAUSE = 3'd1, S_DRAIN = 3'd2,
                         S_GRANT = 3'd3, S_RELEASE = 3'd4;

  logic          clk_49m = 1'b0;
  logic          reset;
  logic          cpu_cen;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_we;
  logic [DW-1:0] cpu_dout;
  logic          hs_access;
  logic [AW-1:0] hs_address;
  logic [DW-1:0] hs_data_in;
  logic          hs_write;
  logic [DW-1:0] hs_data_out;
  logic          hs_grant;
  logic          cpu_pause_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic [2:0]    state_dbg;

  hiscore_ram_arbiter #(.AW(AW), .DW(DW), .DRAIN_CYCLES(8), .RELEASE_CYCLES(4)) dut (
    .clk_49m(clk_49m), .reset(reset), .cpu_cen(cpu_cen), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout), .hs_access(hs_access),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
    .hs_data_out(hs_data_out), .hs_grant(hs_grant), .cpu_pause_n(cpu_pause_n),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #10 clk_49m = ~clk_49m;

  // ---------------- registered RAM model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;

  always @(posedge clk_49m or negedge reset) begin
    if (!reset) ram_dout <= '0;
    else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [15:0] actual(input string t);
    if (t == "grant")    return {15'd0, hs_grant};
    if (t == "pause_n")  return {15'd0, cpu_pause_n};
    if (t == "ram_we")   return {15'd0, ram_we};
    if (t == "state")    return {13'd0, state_dbg};
    if (t == "ram_addr") return {4'd0, ram_addr};
    if (t == "hs_dout")  return {8'd0, hs_data_out};
    if (t == "cpu_dout") return {8'd0, cpu_dout};
    if (t == "mem5a0")   return {8'd0, mem[12'h5A0]};
    if (t == "mem010")   return {8'd0, mem[12'h010]};
    if (t == "mem123")   return {8'd0, mem[12'h123]};
    if (t == "mem200")   return {8'd0, mem[12'h200]};
    return 16'hDEAD;
  endfunction

  // Expectations pushed during a cycle are checked on that cycle's falling edge.
  task automatic expect_v(input string t, input logic [15:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_49m) begin
    while (exp_q.size() > 0) begin
      string       t;
      logic [15:0] e;
      logic [15:0] a;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      a = actual(t);
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", t, a, e, $time);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_cen = 1'b0;
    cpu_we  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cpu_cen = 0; cpu_addr = '0; cpu_din = '0; cpu_we = 0;
    hs_access = 0; hs_address = '0; hs_data_in = '0; hs_write = 0;
    tick(); tick();
    // reset state
    expect_v("grant", 0); expect_v("pause_n", 1); expect_v("ram_we", 0);
    expect_v("state", S_IDLE); expect_v("cpu_dout", 0); expect_v("hs_dout", 0);
    tick();
    reset = 1'b1;
    tick();

    // CPU write 0x11 to 0x5A0 in IDLE
    cpu_addr = 12'h5A0; cpu_din = 8'h11; cpu_we = 1; cpu_cen = 1;
    expect_v("ram_we", 1);
    tick(); cpu_idle();

    // hs_write outside GRANT never reaches ram_we
    hs_address = 12'h123; hs_data_in = 8'hAA; hs_write = 1;
    expect_v("ram_we", 0); expect_v("ram_addr", 12'h5A0);
    tick(); hs_write = 0;

    // request withdrawn before any cpu_cen: back to IDLE, never paused
    hs_access = 1;
    tick();
    expect_v("state", S_PAUSE); expect_v("pause_n", 1);
    hs_access = 0;
    tick();
    expect_v("state", S_IDLE); expect_v("pause_n", 1);
    cpu_cen = 1;
    tick(); cpu_idle();
    expect_v("state", S_IDLE); expect_v("pause_n", 1);
    tick();

    // request, wait for a CPU cycle boundary
    hs_access = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_v("state", S_PAUSE); expect_v("pause_n", 1);
      tick();
    end
    // boundary cycle: CPU write to 0x010 completes normally
    cpu_cen = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_din = 8'h55;
    expect_v("ram_we", 1); expect_v("pause_n", 1);
    tick(); cpu_idle();
    cpu_addr = 12'h5A0;
    expect_v("state", S_DRAIN); expect_v("pause_n", 0); expect_v("grant", 0);
    // grant rises 1+8 clocks after the cpu_cen cycle, i.e. 8 after pause
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) begin
        cpu_cen = 1; cpu_we = 1; cpu_din = 8'h77;
        expect_v("ram_we", 0);
      end
      tick(); cpu_idle();
      expect_v("grant", (i == 8) ? 16'd1 : 16'd0);
      expect_v("pause_n", 0);
    end
    expect_v("state", S_GRANT);

    // GRANT: hiscore write then read back
    hs_address = 12'h5A0; hs_data_in = 8'h3C; hs_write = 1;
    expect_v("ram_we", 1); expect_v("ram_addr", 12'h5A0);
    tick(); hs_write = 0;
    expect_v("mem5a0", 8'h3C);
    tick();
    expect_v("hs_dout", 8'h3C);
    expect_v("cpu_dout", 8'h11);
    hs_address = 12'h010;
    tick();
    expect_v("hs_dout", 8'h55);

    // release: grant drops on the same edge, pause_n rises 4 clocks later
    hs_access = 0;
    expect_v("grant", 1);
    tick();
    expect_v("grant", 0); expect_v("state", S_RELEASE); expect_v("pause_n", 0);
    expect_v("ram_addr", 12'h5A0);
    hs_access = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_v("pause_n", (i == 4) ? 16'd1 : 16'd0);
      expect_v("state", (i == 4) ? S_IDLE : S_RELEASE);
      expect_v("grant", 0);
    end
    tick();
    expect_v("state", S_PAUSE);
    hs_access = 0;
    tick();
    expect_v("state", S_IDLE); expect_v("pause_n", 1);

    // CPU read of 0x5A0 after release sees hiscore data
    cpu_addr = 12'h5A0; cpu_cen = 1;
    tick(); cpu_idle();
    expect_v("cpu_dout", 8'h3C);
    expect_v("mem010", 8'h55);
    expect_v("mem123", 8'h00);
    tick();

    // reset in the middle of GRANT
    hs_access = 1;
    tick();
    cpu_cen = 1;
    tick(); cpu_idle();
    for (int i = 0; i < 8; i++) tick();
    expect_v("grant", 1);
    tick();
    cpu_addr = 12'h0F0;
    hs_address = 12'h200; hs_data_in = 8'h99; hs_write = 1;
    reset = 1'b0;
    #1;
    expect_v("grant", 0); expect_v("pause_n", 1); expect_v("ram_we", 0);
    expect_v("state", S_IDLE); expect_v("ram_addr", 12'h0F0);
    tick();
    hs_write = 0; hs_access = 0;
    expect_v("mem200", 8'h00);
    tick();
    reset = 1'b1;
    tick();
    expect_v("state", S_IDLE);

    // let the monitor drain, bounded
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
